sprite_rom_fetch_arbiter: RTL and testbench



---
 rtl/sprite_pkg.sv | 31 +++
 rtl/sprite_rr_picker.sv | 33 +++
 rtl/sprite_rom_fetch_arbiter.sv | 141 ++++++++++++++
 tb/tb_sprite_rom_fetch_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared constants, FSM encoding and burst-length helper for the sprite ROM fetch arbiter.
package sprite_pkg;

    localparam int SPRITE_ROWS  = 10;
    localparam int SPRITE_ROW_W = 10;
    localparam int SPRITE_IDX_W = 4;

    localparam int REQ_ALIEN = 0;
    localparam int REQ_FX    = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // Rows actually streamed: zero-length counts as one, bursts stop at the last
    // sprite row, and an out-of-range start yields a single blank row.
    function automatic int unsigned burst_len(input int unsigned row,
                                              input int unsigned len,
                                              input int unsigned rows);
        int unsigned n;
        if (row >= rows || len == 0)
            n = 1;
        else if (len < rows - row)
            n = len;
        else
            n = rows - row;
        return n;
    endfunction

endpackage

// File: rtl/sprite_rr_picker.sv
// Combinational picker: first asserted valid searching upward (with wrap) from i_start.
module sprite_rr_picker
    import sprite_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [ID_W-1:0]    i_start,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_index,
    output logic               o_any
);

    logic [ID_W-1:0] w_idx;

    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        o_grant = '0;
        o_index = '0;
        o_any   = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = ID_W'((int'(i_start) + k) % NUM_REQ);
            if (!o_any && i_valid[w_idx]) begin
                o_any          = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_index        = w_idx;
            end
        end
    end

endmodule

// File: rtl/sprite_rom_fetch_arbiter.sv
// Arbitrates row bursts from several renderers onto one combinational sprite ROM.
// Define SPRITE_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module sprite_rom_fetch_arbiter
    import sprite_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ROWS    = SPRITE_ROWS,
    parameter int ROW_W   = SPRITE_ROW_W,
    parameter int IDX_W   = SPRITE_IDX_W,
    parameter int ID_W    = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*IDX_W-1:0] req_row,
    input  logic [NUM_REQ*IDX_W-1:0] req_len,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [IDX_W-1:0]         rom_row_index,
    input  logic [ROW_W-1:0]         rom_row_data,
    output logic                     rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic [IDX_W-1:0]         rsp_row,
    output logic [ROW_W-1:0]         rsp_data,
    output logic                     rsp_last,
    output logic                     busy
);

    localparam int CNT_W = IDX_W + 1;

    arb_state_e         r_state, w_state_next;
    logic [CNT_W-1:0]   r_remaining;
    logic [ID_W-1:0]    r_id;
    logic               r_oob;
    logic [IDX_W-1:0]   r_rom_row_index;
    logic               r_rsp_valid, r_rsp_last;
    logic [ID_W-1:0]    r_rsp_id;
    logic [IDX_W-1:0]   r_rsp_row;
    logic [ROW_W-1:0]   r_rsp_data;

    logic               w_issue, w_final_issue, w_window, w_accept;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_grant_idx, w_search_start;
    logic               w_grant_any;
    logic [IDX_W-1:0]   w_start_row, w_start_len;
    logic [CNT_W-1:0]   w_len_eff;

`ifdef SPRITE_ARB_FIXED_PRIO_EN
    assign w_search_start = '0;
`else
    logic [ID_W-1:0] r_last_granted;

    // Reset value makes requester 0 the first winner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_last_granted <= ID_W'(NUM_REQ - 1);
        else if (w_accept)
            r_last_granted <= w_grant_idx;
    end

    assign w_search_start = (r_last_granted == ID_W'(NUM_REQ - 1)) ? '0
                                                                   : r_last_granted + ID_W'(1);
`endif

    sprite_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .i_valid (req_valid),
        .i_start (w_search_start),
        .o_grant (w_grant),
        .o_index (w_grant_idx),
        .o_any   (w_grant_any)
    );

    // The grant window also opens on the final issue so bursts chain without a bubble.
    assign w_issue       = (r_state == BURST);
    assign w_final_issue = w_issue && (r_remaining == CNT_W'(1));
    assign w_window      = (r_state == IDLE) || w_final_issue;
    assign w_accept      = w_window && w_grant_any && !reset;
    assign req_ready     = w_accept ? w_grant : '0;

    assign w_start_row = req_row[int'(w_grant_idx)*IDX_W +: IDX_W];
    assign w_start_len = req_len[int'(w_grant_idx)*IDX_W +: IDX_W];
    assign w_len_eff   = CNT_W'(burst_len(32'(w_start_row), 32'(w_start_len), ROWS));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (w_accept)
            w_state_next = BURST;
        else if (w_final_issue)
            w_state_next = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rom_row_index <= '0;
            r_remaining     <= '0;
            r_id            <= '0;
            r_oob           <= 1'b0;
            r_rsp_valid     <= 1'b0;
            r_rsp_last      <= 1'b0;
            r_rsp_id        <= '0;
            r_rsp_row       <= '0;
            r_rsp_data      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_rsp_valid <= w_issue;
            r_rsp_last  <= w_final_issue;
            if (w_issue) begin
                r_rsp_id        <= r_id;
                r_rsp_row       <= r_rom_row_index;
                r_rsp_data      <= r_oob ? '0 : rom_row_data;
                r_rom_row_index <= r_rom_row_index + IDX_W'(1);
                r_remaining     <= r_remaining - CNT_W'(1);
            end
            // A new accept overrides the advance of a just-finished burst.
            if (w_accept) begin
                r_rom_row_index <= w_start_row;
                r_remaining     <= w_len_eff;
                r_id            <= w_grant_idx;
                r_oob           <= ({1'b0, w_start_row} >= CNT_W'(ROWS));
            end
        end
    end

    assign rom_row_index = r_rom_row_index;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_id        = r_rsp_id;
    assign rsp_row       = r_rsp_row;
    assign rsp_data      = r_rsp_data;
    assign rsp_last      = r_rsp_last;
    assign busy          = (r_state == BURST);

endmodule

// File: tb/tb_sprite_rom_fetch_arbiter.sv
// Self-checking bench: directed bursts plus random traffic against a transaction-level model.
module tb_sprite_rom_fetch_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ROWS    = 10;
    localparam int ROW_W   = 10;
    localparam int IDX_W   = 4;
    localparam int ID_W    = 1;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*IDX_W-1:0] req_row;
    logic [NUM_REQ*IDX_W-1:0] req_len;
    logic [NUM_REQ-1:0]       req_ready;
    logic [IDX_W-1:0]         rom_row_index;
    logic [ROW_W-1:0]         rom_row_data;
    logic                     rsp_valid;
    logic [ID_W-1:0]          rsp_id;
    logic [IDX_W-1:0]         rsp_row;
    logic [ROW_W-1:0]         rsp_data;
    logic                     rsp_last;
    logic                     busy;

    always #5 clk = ~clk;

    sprite_rom_fetch_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ROWS    (ROWS),
        .ROW_W   (ROW_W),
        .IDX_W   (IDX_W),
        .ID_W    (ID_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_row       (req_row),
        .req_len       (req_len),
        .req_ready     (req_ready),
        .rom_row_index (rom_row_index),
        .rom_row_data  (rom_row_data),
        .rsp_valid     (rsp_valid),
        .rsp_id        (rsp_id),
        .rsp_row       (rsp_row),
        .rsp_data      (rsp_data),
        .rsp_last      (rsp_last),
        .busy          (busy)
    );

    // Sprite ROM contents; out-of-range addresses return junk the arbiter must ignore.
    function automatic logic [ROW_W-1:0] rom_lookup(input logic [IDX_W-1:0] idx);
        case (idx)
            4'd0: rom_lookup = 10'h0FC;
            4'd1: rom_lookup = 10'h1FE;
            4'd2: rom_lookup = 10'h36D;
            4'd3: rom_lookup = 10'h3FF;
            4'd4: rom_lookup = 10'h1FE;
            4'd5: rom_lookup = 10'h084;
            4'd6: rom_lookup = 10'h102;
            4'd7: rom_lookup = 10'h201;
            4'd8: rom_lookup = 10'h306;
            4'd9: rom_lookup = 10'h1FE;
            default: rom_lookup = 10'h2AA;
        endcase
    endfunction

    assign rom_row_data = rom_lookup(rom_row_index);

    int n_vec;
    int n_err;

    // Reference model: rows left in the current burst, next row address, owner.
    int               m_rem;
    int               m_row;
    int               m_id;
    int               m_last;
    bit               m_oob;
    bit               e_valid;
    bit               e_last;
    int               e_id;
    int               e_row;
    logic [ROW_W-1:0] e_data;
    bit               auto_drop;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int eff_len(input int row, input int len);
        if (row >= ROWS) return 1;
        if (len == 0) return 1;
        return (len < ROWS - row) ? len : ROWS - row;
    endfunction

    function automatic int pick(input logic [NUM_REQ-1:0] v);
        int start;
`ifdef SPRITE_ARB_FIXED_PRIO_EN
        start = 0;
`else
        start = (m_last + 1) % NUM_REQ;
`endif
        for (int k = 0; k < NUM_REQ; k++)
            if (v[(start + k) % NUM_REQ]) return (start + k) % NUM_REQ;
        return -1;
    endfunction

    task automatic model_reset();
        m_rem   = 0;
        m_row   = 0;
        m_id    = 0;
        m_last  = NUM_REQ - 1;
        m_oob   = 1'b0;
        e_valid = 1'b0;
    endtask

    // One clock: compare at negedge, then advance the model across the posedge.
    task automatic cycle();
        int                 win;
        int                 start;
        int                 len;
        logic [NUM_REQ-1:0] exp_ready;
        @(negedge clk);
        win       = pick(req_valid);
        exp_ready = '0;
        if (m_rem <= 1 && win >= 0) exp_ready[win] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("busy", 32'(busy), 32'(m_rem > 0));
        check("rom_row_index", 32'(rom_row_index), m_row);
        check("rsp_valid", 32'(rsp_valid), 32'(e_valid));
        if (e_valid) begin
            check("rsp_id", 32'(rsp_id), e_id);
            check("rsp_row", 32'(rsp_row), e_row);
            check("rsp_data", 32'(rsp_data), 32'(e_data));
            check("rsp_last", 32'(rsp_last), 32'(e_last));
        end
        @(posedge clk);
        if (m_rem > 0) begin
            e_valid = 1'b1;
            e_id    = m_id;
            e_row   = m_row;
            e_data  = m_oob ? '0 : rom_lookup(IDX_W'(m_row));
            e_last  = (m_rem == 1);
            m_row   = (m_row + 1) % (1 << IDX_W);
            m_rem   = m_rem - 1;
        end else begin
            e_valid = 1'b0;
        end
        if (exp_ready != '0) begin
            start  = int'(req_row[win*IDX_W +: IDX_W]);
            len    = int'(req_len[win*IDX_W +: IDX_W]);
            m_id   = win;
            m_row  = start;
            m_oob  = (start >= ROWS);
            m_rem  = eff_len(start, len);
            m_last = win;
        end
        #1;
        if (auto_drop) req_valid = req_valid & ~exp_ready;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_last", 32'(rsp_last), 0);
        check("rst_rsp_data", 32'(rsp_data), 0);
        check("rst_rsp_id", 32'(rsp_id), 0);
        check("rst_rsp_row", 32'(rsp_row), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_rom_row_index", 32'(rom_row_index), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // Step at least one clock, then until a response is visible or the budget expires.
    task automatic wait_rsp(input string tag, input int max_cycles, output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!rsp_valid && n < max_cycles);
        check({tag, "_seen"}, 32'(rsp_valid), 1);
    endtask

    task automatic rsp_expect(input string tag, input int id, input int row,
                              input logic [ROW_W-1:0] data, input bit last);
        check({tag, "_id"}, 32'(rsp_id), id);
        check({tag, "_row"}, 32'(rsp_row), row);
        check({tag, "_data"}, 32'(rsp_data), 32'(data));
        check({tag, "_last"}, 32'(rsp_last), 32'(last));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int first_id;
        n_vec     = 0;
        n_err     = 0;
        reset     = 1'b1;
        req_valid = '0;
        req_row   = '0;
        req_len   = '0;
        auto_drop = 1'b1;
        model_reset();
        @(posedge clk);
        #1;

        // Reset with a pending request: no grant may leak out during reset.
        req_valid = 2'b01;
        req_row   = {4'd0, 4'd0};
        req_len   = {4'd0, 4'd1};
        do_reset();

        // Single row, check two-cycle latency from the accepting cycle.
        wait_rsp("t1", 6, n);
        check("t1_latency", 32'(n), 2);
        rsp_expect("t1", 0, 0, 10'h0FC, 1'b1);
        repeat (2) cycle();

        // Both requesters from reset: req0 first, req1 chained with no bubble.
        do_reset();
        req_row   = {4'd2, 4'd2};
        req_len   = {4'd2, 4'd2};
        req_valid = 2'b11;
        wait_rsp("t2a", 6, n);
        rsp_expect("t2a", 0, 2, 10'h36D, 1'b0);
        wait_rsp("t2b", 1, n);
        rsp_expect("t2b", 0, 3, 10'h3FF, 1'b1);
        wait_rsp("t2c", 1, n);
        rsp_expect("t2c", 1, 2, 10'h36D, 1'b0);
        wait_rsp("t2d", 1, n);
        rsp_expect("t2d", 1, 3, 10'h3FF, 1'b1);
        repeat (2) cycle();

        // req0 alone, then both: round-robin hands the next win to req1.
        req_valid = 2'b01;
        wait_rsp("t2e", 6, n);
        wait_rsp("t2f", 1, n);
        repeat (2) cycle();
        req_valid = 2'b11;
        wait_rsp("t2g", 6, n);
`ifdef SPRITE_ARB_FIXED_PRIO_EN
        first_id = 0;
`else
        first_id = 1;
`endif
        check("t2g_rr_id", 32'(rsp_id), first_id);
        repeat (8) cycle();

        // Burst clipped at the last sprite row.
        req_row   = {4'd8, 4'd0};
        req_len   = {4'd5, 4'd0};
        req_valid = 2'b10;
        wait_rsp("t3a", 6, n);
        rsp_expect("t3a", 1, 8, 10'h306, 1'b0);
        wait_rsp("t3b", 1, n);
        rsp_expect("t3b", 1, 9, 10'h1FE, 1'b1);
        cycle();
        check("t3_clip_end", 32'(rsp_valid), 0);

        // Out-of-range start gives one blank row; zero length gives one row.
        req_row   = {4'd0, 4'd12};
        req_len   = {4'd0, 4'd3};
        req_valid = 2'b01;
        wait_rsp("t4a", 6, n);
        rsp_expect("t4a", 0, 12, 10'h000, 1'b1);
        cycle();
        check("t4_oob_single", 32'(rsp_valid), 0);
        req_row   = {4'd0, 4'd4};
        req_len   = {4'd0, 4'd0};
        req_valid = 2'b01;
        wait_rsp("t4b", 6, n);
        rsp_expect("t4b", 0, 4, 10'h1FE, 1'b1);
        repeat (2) cycle();

        // Reset while the third row of a full-height burst is being issued.
        req_row   = {4'd0, 4'd0};
        req_len   = {4'd0, 4'd10};
        req_valid = 2'b01;
        wait_rsp("t5a", 6, n);
        wait_rsp("t5b", 1, n);
        rsp_expect("t5b", 0, 1, 10'h1FE, 1'b0);
        #2;
        check("t5_busy_before", 32'(busy), 1);
        do_reset();
        req_row   = {4'd0, 4'd3};
        req_len   = {4'd0, 4'd1};
        req_valid = 2'b01;
        wait_rsp("t5c", 6, n);
        check("t5_latency", 32'(n), 2);
        rsp_expect("t5c", 0, 3, 10'h3FF, 1'b1);
        repeat (2) cycle();

        // Both held valid with changing parameters: arbitration order under contention.
        auto_drop = 1'b0;
        req_valid = 2'b11;
        for (int i = 0; i < 40; i++) begin
            req_row = (NUM_REQ*IDX_W)'($urandom);
            req_len = (NUM_REQ*IDX_W)'($urandom);
            cycle();
        end

        // Fully random traffic, including out-of-range starts and zero lengths.
        for (int i = 0; i < 400; i++) begin
            req_valid = NUM_REQ'($urandom);
            req_row   = (NUM_REQ*IDX_W)'($urandom);
            req_len   = (NUM_REQ*IDX_W)'($urandom);
            cycle();
        end

        req_valid = '0;
        repeat (12) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
